// File: rtl/cpu_pkg.sv
// Shared constants and encodings for the data-memory slice: widths, arbiter
// state encoding and requester port ids.
package cpu_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_L = 1'b1
  } port_t;

  function automatic port_t other_port(input port_t p);
    return (p == PORT_C) ? PORT_L : PORT_C;
  endfunction

endpackage

// File: rtl/dmem_core.sv
// 2**ADDR_W x DATA_W register array: async clear, one write port and one
// registered read port whose output holds until the next read.
module dmem_core
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              osc_clock,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: every word is cleared on reset, which keeps this a flop array rather
  // than an inferable RAM; that is intended at this 16-word size.
  always_ff @(posedge osc_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the shared data memory between the CPU (port C) and
// the loader (port L), with bounded loader bursts and a CPU stall counter.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int MAX_LOCK = 8,
  parameter int STALL_W  = 8
) (
  input  logic               osc_clock,
  input  logic               reset,
  input  logic               c_req,
  input  logic               c_we,
  input  logic [ADDR_W-1:0]  c_addr,
  input  logic [DATA_W-1:0]  c_wdata,
  output logic               c_gnt,
  output logic               c_rvalid,
  output logic [DATA_W-1:0]  c_rdata,
  input  logic               l_req,
  input  logic               l_we,
  input  logic [ADDR_W-1:0]  l_addr,
  input  logic [DATA_W-1:0]  l_wdata,
  input  logic               l_lock,
  output logic               l_gnt,
  output logic               l_rvalid,
  output logic [DATA_W-1:0]  l_rdata,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int LOCK_W = 4;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCK - 1);

  arb_state_t        state_q;
  port_t             prio_q;
  logic [LOCK_W-1:0] lock_cnt_q;
  logic [LOCK_W-1:0] lock_cnt_inc;
  logic              force_release;
  logic              c_rvalid_q, l_rvalid_q;
  logic [DATA_W-1:0] c_rdata_q, l_rdata_q;
  logic [DATA_W-1:0] core_rdata;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // NOTE: both grants get a default before any branch so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    c_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!reset) begin
      case (state_q)
        ARB: begin
          c_gnt = c_req & (~l_req | (prio_q == PORT_C));
          l_gnt = l_req & (~c_req | (prio_q == PORT_L));
        end
        LOCK:    l_gnt = l_req;
        default: ;
      endcase
    end
  end

  assign mem_we    = (c_gnt & c_we) | (l_gnt & l_we);
  assign mem_re    = (c_gnt & ~c_we) | (l_gnt & ~l_we);
  assign mem_addr  = l_gnt ? l_addr : c_addr;
  assign mem_wdata = l_gnt ? l_wdata : c_wdata;

  dmem_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_core (
    .osc_clock (osc_clock),
    .reset     (reset),
    .we        (mem_we),
    .re        (mem_re),
    .addr      (mem_addr),
    .wdata     (mem_wdata),
    .rdata     (core_rdata)
  );

  // The ARB grant that opens a burst is the first of the MAX_LOCK cycles, so
  // the burst ends in the LOCK cycle where the counter reaches MAX_LOCK-1.
  assign lock_cnt_inc  = lock_cnt_q + LOCK_W'(1);
  assign force_release = c_req & (lock_cnt_inc >= LOCK_LAST);

  // NOTE: state is updated with non-blocking assignments only, so every branch
  // reads the pre-edge values regardless of statement order.
  always_ff @(posedge osc_clock or posedge reset) begin
    if (reset) begin
      state_q    <= ARB;
      prio_q     <= PORT_C;
      lock_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (c_gnt) prio_q <= other_port(PORT_C);
          if (l_gnt) begin
            prio_q <= other_port(PORT_L);
            if (l_lock) begin
              state_q    <= LOCK;
              lock_cnt_q <= '0;
            end
          end
        end
        LOCK: begin
          if (c_req) lock_cnt_q <= lock_cnt_inc;
          if (!l_lock || !l_req || force_release) begin
            state_q <= ARB;
            prio_q  <= PORT_C;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  always_ff @(posedge osc_clock or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      c_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      if (c_req && !c_gnt && (stall_cnt != '1)) stall_cnt <= stall_cnt + STALL_W'(1);
      c_rvalid_q <= c_gnt & ~c_we;
      l_rvalid_q <= l_gnt & ~l_we;
      if (c_rvalid_q) c_rdata_q <= core_rdata;
      if (l_rvalid_q) l_rdata_q <= core_rdata;
    end
  end

  // The core's read register is shared; each port keeps its own last value.
  assign c_rvalid = c_rvalid_q;
  assign l_rvalid = l_rvalid_q;
  assign c_rdata  = c_rvalid_q ? core_rdata : c_rdata_q;
  assign l_rdata  = l_rvalid_q ? core_rdata : l_rdata_q;

endmodule
